// File: rtl/rps_stream_classifier_pkg.sv
// Shared types and width helpers for the rock/paper/scissors stream classifier.
// Provides the class and FSM state enums plus SW/CW/TW width functions.
package rps_pkg;

    typedef enum logic [1:0] {
        RPS_ROCK     = 2'd0,
        RPS_PAPER    = 2'd1,
        RPS_SCISSORS = 2'd2
    } rps_class_e;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } rps_state_e;

    // Bits to hold a pixel count in 0..length*width
    function automatic int sum_w(input int length, input int width);
        return $clog2(length * width + 1);
    endfunction

    // Bits to hold a column index in 0..width
    function automatic int col_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Bits to hold a transition count in 0..length-1
    function automatic int trans_w(input int length);
        return $clog2(length);
    endfunction

endpackage

// File: rtl/rps_stream_classifier_if.sv
// Row-in / result-out handshake bundle for rps_stream_classifier.
// slave: classifier side; master: row source and result consumer side.
interface rps_stream_classifier_if #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 32
);
    import rps_pkg::*;

    localparam int SW = sum_w(LENGTH, WIDTH);
    localparam int CW = col_w(WIDTH);
    localparam int TW = trans_w(LENGTH);

    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_data;

    logic             res_valid;
    logic             res_ready;
    rps_class_e       result;
    logic [SW-1:0]    res_sum;
    logic [SW-1:0]    res_sum_left;
    logic [CW-1:0]    res_leftmost;
    logic [TW-1:0]    res_transitions;

    modport slave (
        input  row_valid, row_data, res_ready,
        output row_ready, res_valid, result,
        output res_sum, res_sum_left, res_leftmost, res_transitions
    );

    modport master (
        output row_valid, row_data, res_ready,
        input  row_ready, res_valid, result,
        input  res_sum, res_sum_left, res_leftmost, res_transitions
    );

endinterface

// File: rtl/rps_row_features.sv
// Combinational per-row features: popcount, left-region popcount, lowest set column.
// Ports: row in; pop, pop_left, lowest out (lowest = WIDTH when row is empty).
module rps_row_features #(
    parameter int WIDTH = 32,
    parameter int LEFT  = 8
) (
    input  logic [WIDTH-1:0]         row,
    output logic [$clog2(WIDTH+1)-1:0] pop,
    output logic [$clog2(WIDTH+1)-1:0] pop_left,
    output logic [$clog2(WIDTH+1)-1:0] lowest
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        pop      = '0;
        pop_left = '0;
        lowest   = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CW'(row[i]);
            if (i < LEFT) begin
                pop_left = pop_left + CW'(row[i]);
            end
        end
        // Scan downward so the lowest set bit wins
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (row[i]) begin
                lowest = CW'(i);
            end
        end
    end

endmodule

// File: rtl/rps_stream_classifier.sv
// Frame-buffered rock/paper/scissors classifier: rows in, class + features out.
// Ports: clk, rst_n (async active-low), bus (slave modport of rps_stream_classifier_if).
module rps_stream_classifier
    import rps_pkg::*;
#(
    parameter int LENGTH         = 32,
    parameter int WIDTH          = 32,
    parameter int LEFT           = 8,
    parameter int SHIFT          = 4,
    parameter int LEFT_DIV       = 50,
    parameter int SCISSORS_TRANS = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    rps_stream_classifier_if.slave bus
);

    localparam int SW     = sum_w(LENGTH, WIDTH);
    localparam int CW     = col_w(WIDTH);
    localparam int TW     = trans_w(LENGTH);
    localparam int RW     = trans_w(LENGTH);
    localparam int XW     = $clog2(WIDTH + SHIFT + 1);
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int THRESH = (LENGTH * WIDTH) / LEFT_DIV;
    // A target beyond LENGTH-1 transitions can never be reached
    localparam bit SC_OK  = (SCISSORS_TRANS <= LENGTH - 1);

    rps_state_e state_q, state_d;

    logic [WIDTH-1:0] buffer [LENGTH];

    logic [RW-1:0] row_idx_q;
    logic [RW-1:0] scan_idx_q;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_left_q;
    logic [CW-1:0] leftmost_q;
    logic [TW-1:0] trans_q;

    rps_class_e    res_class_q;
    logic [SW-1:0] res_sum_q;
    logic [SW-1:0] res_sum_left_q;
    logic [CW-1:0] res_leftmost_q;
    logic [TW-1:0] res_trans_q;

    logic [CW-1:0] f_pop;
    logic [CW-1:0] f_pop_left;
    logic [CW-1:0] f_low;

    logic             accept;
    logic             last_row;
    logic             last_scan;
    logic [XW-1:0]    col;
    logic             col_ok;
    logic [IW-1:0]    col_idx;
    logic [WIDTH-1:0] row_a;
    logic [WIDTH-1:0] row_b;
    logic             trans_inc;
    logic [TW-1:0]    trans_d;
    rps_class_e       class_d;

    rps_row_features #(
        .WIDTH (WIDTH),
        .LEFT  (LEFT)
    ) u_feat (
        .row      (bus.row_data),
        .pop      (f_pop),
        .pop_left (f_pop_left),
        .lowest   (f_low)
    );

    assign accept    = (state_q == ACCUM) && bus.row_valid;
    assign last_row  = (row_idx_q == RW'(LENGTH - 1));
    assign last_scan = (scan_idx_q == RW'(LENGTH - 2));

    // Column may run past the image; out-of-range means no transitions
    assign col     = XW'(leftmost_q) + XW'(SHIFT);
    assign col_ok  = (col < XW'(WIDTH));
    assign col_idx = col[IW-1:0];

    assign row_a     = buffer[scan_idx_q];
    assign row_b     = buffer[scan_idx_q + RW'(1)];
    assign trans_inc = col_ok && (row_a[col_idx] != row_b[col_idx]);
    assign trans_d   = trans_q + TW'(trans_inc);

    // Classification uses the count including this final scan step
    always_comb begin
        class_d = RPS_ROCK;
        if (SC_OK && (trans_d == TW'(SCISSORS_TRANS))) begin
            class_d = RPS_SCISSORS;
        end else if (sum_left_q > SW'(THRESH)) begin
            class_d = RPS_PAPER;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (accept && last_row) state_d = SCAN;
            SCAN:  if (last_scan) state_d = DONE;
            DONE:  if (bus.res_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame storage is not reset; stale contents are always overwritten first
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[row_idx_q] <= bus.row_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx_q      <= '0;
            scan_idx_q     <= '0;
            sum_q          <= '0;
            sum_left_q     <= '0;
            leftmost_q     <= CW'(WIDTH);
            trans_q        <= '0;
            res_class_q    <= RPS_ROCK;
            res_sum_q      <= '0;
            res_sum_left_q <= '0;
            res_leftmost_q <= '0;
            res_trans_q    <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        row_idx_q  <= last_row ? '0 : row_idx_q + RW'(1);
                        sum_q      <= sum_q + SW'(f_pop);
                        sum_left_q <= sum_left_q + SW'(f_pop_left);
                        if (f_low < leftmost_q) begin
                            leftmost_q <= f_low;
                        end
                        if (last_row) begin
                            scan_idx_q <= '0;
                        end
                    end
                end
                SCAN: begin
                    trans_q    <= trans_d;
                    scan_idx_q <= scan_idx_q + RW'(1);
                    if (last_scan) begin
                        res_class_q    <= class_d;
                        res_sum_q      <= sum_q;
                        res_sum_left_q <= sum_left_q;
                        res_leftmost_q <= leftmost_q;
                        res_trans_q    <= trans_d;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        row_idx_q      <= '0;
                        scan_idx_q     <= '0;
                        sum_q          <= '0;
                        sum_left_q     <= '0;
                        leftmost_q     <= CW'(WIDTH);
                        trans_q        <= '0;
                        res_class_q    <= RPS_ROCK;
                        res_sum_q      <= '0;
                        res_sum_left_q <= '0;
                        res_leftmost_q <= '0;
                        res_trans_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.row_ready       = (state_q == ACCUM);
    assign bus.res_valid       = (state_q == DONE);
    assign bus.result          = res_class_q;
    assign bus.res_sum         = res_sum_q;
    assign bus.res_sum_left    = res_sum_left_q;
    assign bus.res_leftmost    = res_leftmost_q;
    assign bus.res_transitions = res_trans_q;

endmodule

// File: tb/tb_rps_stream_classifier.sv
// Self-checking bench for rps_stream_classifier (8x16 frames, LEFT=4, SHIFT=2).
// Directed and random frames checked against a frame-level reference model.
module tb_rps_stream_classifier;

    localparam int L    = 8;
    localparam int W    = 16;
    localparam int LFT  = 4;
    localparam int SH   = 2;
    localparam int DIV  = 50;
    localparam int STR  = 4;
    localparam int THR  = (L * W) / DIV;

    typedef logic [W-1:0] frame_t [L];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rps_stream_classifier_if #(.LENGTH(L), .WIDTH(W)) bus ();

    rps_stream_classifier #(
        .LENGTH         (L),
        .WIDTH          (W),
        .LEFT           (LFT),
        .SHIFT          (SH),
        .LEFT_DIV       (DIV),
        .SCISSORS_TRANS (STR)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level reference: features from whole-image arithmetic
    task automatic model(input frame_t f, output int s, output int sl,
                         output int lm, output int tr, output int cls);
        int col;
        s  = 0;
        sl = 0;
        tr = 0;
        lm = W;
        for (int r = 0; r < L; r++) begin
            s  += $countones(f[r]);
            sl += $countones(f[r] & ((1 << LFT) - 1));
        end
        for (int c = W - 1; c >= 0; c--) begin
            for (int r = 0; r < L; r++) begin
                if (f[r][c]) lm = c;
            end
        end
        col = lm + SH;
        if (col < W) begin
            for (int r = 0; r < L - 1; r++) begin
                if (f[r][col] != f[r+1][col]) tr++;
            end
        end
        if (tr == STR)      cls = 2;
        else if (sl > THR)  cls = 1;
        else                cls = 0;
    endtask

    // Starts and ends just after the edge accepting the last row
    task automatic send_frame(input frame_t f, input bit gaps);
        for (int r = 0; r < L; r++) begin
            @(negedge clk);
            if (gaps) begin
                bus.row_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.row_valid = 1'b1;
            bus.row_data  = f[r];
            chk("row_ready_accum", bus.row_ready, 1);
            @(posedge clk);
        end
    endtask

    task automatic get_result(input frame_t f, input int hold, input string tag);
        int s, sl, lm, tr, cls;
        int cnt;
        bit got;
        model(f, s, sl, lm, tr, cls);
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.row_valid = 1'b0;
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            cnt++;
        end
        chk({tag, "_res_valid_seen"}, got, 1);
        chk({tag, "_latency"}, cnt, L - 1);
        chk({tag, "_result"}, bus.result, cls);
        chk({tag, "_sum"}, bus.res_sum, s);
        chk({tag, "_sum_left"}, bus.res_sum_left, sl);
        chk({tag, "_leftmost"}, bus.res_leftmost, lm);
        chk({tag, "_trans"}, bus.res_transitions, tr);
        for (int i = 0; i < hold; i++) begin
            bus.row_valid = 1'b1;
            bus.row_data  = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.res_valid, 1);
            chk({tag, "_hold_ready"}, bus.row_ready, 0);
            chk({tag, "_hold_result"}, bus.result, cls);
            chk({tag, "_hold_sum"}, bus.res_sum, s);
            chk({tag, "_hold_sum_left"}, bus.res_sum_left, sl);
            chk({tag, "_hold_leftmost"}, bus.res_leftmost, lm);
            chk({tag, "_hold_trans"}, bus.res_transitions, tr);
        end
        bus.row_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({tag, "_ready_after_ack"}, bus.row_ready, 1);
        chk({tag, "_valid_after_ack"}, bus.res_valid, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_row_ready"}, bus.row_ready, 1);
        chk({tag, "_result"}, bus.result, 0);
        chk({tag, "_sum"}, bus.res_sum, 0);
        chk({tag, "_sum_left"}, bus.res_sum_left, 0);
        chk({tag, "_leftmost"}, bus.res_leftmost, 0);
        chk({tag, "_trans"}, bus.res_transitions, 0);
    endtask

    initial begin
        frame_t f;
        frame_t sc;
        int c;
        bit got;

        rst_n         = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.res_ready = 1'b0;
        #2;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All-zero frame
        for (int r = 0; r < L; r++) f[r] = '0;
        send_frame(f, 1'b0);
        get_result(f, 0, "zero");

        // Paper: left block in rows 0-1
        for (int r = 0; r < L; r++) f[r] = (r < 2) ? 16'h000F : 16'h0000;
        send_frame(f, 1'b1);
        get_result(f, 0, "paper");

        // Scissors with 10 cycles of backpressure
        for (int r = 0; r < L; r++) sc[r] = '0;
        sc[0][5] = 1'b1;
        sc[0][7] = 1'b1;
        sc[3][7] = 1'b1;
        sc[4][7] = 1'b1;
        sc[7][7] = 1'b1;
        send_frame(sc, 1'b0);
        get_result(sc, 10, "scissors_bp");

        // Leftmost column pushes scan column off the image
        for (int r = 0; r < L; r++) f[r] = '0;
        f[0][15] = 1'b1;
        f[2][15] = 1'b1;
        f[4][15] = 1'b1;
        send_frame(f, 1'b1);
        get_result(f, 0, "oor");

        // Random frames: dense, sparse and transition-rich single-column
        for (int k = 0; k < 9; k++) begin
            c = $urandom_range(0, W - 3);
            for (int r = 0; r < L; r++) begin
                case (k % 3)
                    0: f[r] = W'($urandom);
                    1: f[r] = W'($urandom & $urandom & $urandom);
                    default: begin
                        f[r] = '0;
                        f[r][c + SH] = $urandom_range(0, 1) == 1;
                    end
                endcase
            end
            if (k % 3 == 2) f[0][c] = 1'b1;
            send_frame(f, k[0]);
            get_result(f, (k == 4) ? 3 : 0, "rand");
        end

        // Reset mid-frame after 3 rows, then a clean scissors frame
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            bus.row_valid = 1'b1;
            bus.row_data  = 16'hFFFF;
            @(posedge clk);
        end
        @(negedge clk);
        bus.row_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("reset_midframe");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(sc, 1'b0);
        get_result(sc, 0, "after_reset");

        // Reset while holding a result
        send_frame(sc, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.row_valid = 1'b0;
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_before_reset", got, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_in_done");
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < L; r++) f[r] = '0;
        f[1] = 16'h0003;
        f[5] = 16'h0101;
        send_frame(f, 1'b1);
        get_result(f, 0, "post_done_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
